ex_operand_issue: RTL and testbench

//  ID/EX pipeline stage sitting directly upstream of the ALU: captures a decoded instruction, drives DATA1/DATA2/SELECT.

---
 rtl/ex_operand_issue_pkg.sv | 60 ++++++
 rtl/ex_operand_issue_forward.sv | 32 +++
 rtl/ex_operand_issue.sv | 154 +++++++++++++++
 tb/tb_ex_operand_issue.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_operand_issue_pkg.sv
// ALU opcode encodings, latency classes and ID/EX bundle types
// shared by the decoder, the issue stage and the ALU.
package ex_operand_issue_pkg;

    localparam logic [5:0] SEL_ADD    = 6'b000000;
    localparam logic [5:0] SEL_SUB    = 6'b000001;
    localparam logic [5:0] SEL_AND    = 6'b000010;
    localparam logic [5:0] SEL_OR     = 6'b000011;
    localparam logic [5:0] SEL_XOR    = 6'b000100;
    localparam logic [5:0] SEL_SLL    = 6'b000101;
    localparam logic [5:0] SEL_SRL    = 6'b000110;
    localparam logic [5:0] SEL_SRA    = 6'b000111;
    localparam logic [5:0] SEL_MUL    = 6'b001000;
    localparam logic [5:0] SEL_MULH   = 6'b001001;
    localparam logic [5:0] SEL_MULHSU = 6'b001010;
    localparam logic [5:0] SEL_MULHU  = 6'b001011;
    localparam logic [5:0] SEL_DIV    = 6'b001100;
    localparam logic [5:0] SEL_DIVU   = 6'b001101;
    localparam logic [5:0] SEL_REM    = 6'b001110;
    localparam logic [5:0] SEL_REMU   = 6'b001111;

    localparam int OPSEL_PC_BIT  = 0;
    localparam int OPSEL_IMM_BIT = 1;

    typedef enum logic [1:0] {
        LAT_ALU,
        LAT_MUL,
        LAT_DIV
    } lat_class_e;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_FIRST,
        ST_WAIT,
        ST_DONE
    } issue_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [4:0]  rd_addr;
        logic [5:0]  select;
        logic [1:0]  op_sel;
    } id_ex_t;

    function automatic lat_class_e lat_class(input logic [5:0] sel);
        lat_class_e c;
        unique case (1'b1)
            (sel[5:2] == 4'b0010): c = LAT_MUL;
            (sel[5:2] == 4'b0011): c = LAT_DIV;
            default:               c = LAT_ALU;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/ex_operand_issue_forward.sv
// Bypass select for one source operand: the youngest in-flight
// writer wins, x0 is never bypassed.
module operand_forward
    import ex_operand_issue_pkg::*;
(
    input  logic [4:0]  rs_addr,
    input  logic [31:0] rf_data,
    input  logic [4:0]  exmem_rd_addr,
    input  logic [31:0] exmem_result,
    input  logic [4:0]  memwb_rd_addr,
    input  logic [31:0] memwb_result,
    output logic [31:0] fwd_data
);

    logic nz;
    logic hit_ex;
    logic hit_wb;

    assign nz     = (rs_addr != 5'd0);
    assign hit_ex = nz && (exmem_rd_addr == rs_addr);
    assign hit_wb = nz && (memwb_rd_addr == rs_addr) && !hit_ex;

    always_comb begin
        fwd_data = rf_data;
        unique case (1'b1)
            hit_ex:  fwd_data = exmem_result;
            hit_wb:  fwd_data = memwb_result;
            default: fwd_data = rf_data;
        endcase
    end

endmodule

// File: rtl/ex_operand_issue.sv
// ID/EX issue stage: captures decoded ops, resolves bypasses on the
// first EX cycle and holds operands for multi-cycle RV32M ops.
module ex_operand_issue
    import ex_operand_issue_pkg::*;
#(
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_valid,
    output logic        id_ready,
    input  logic [31:0] id_pc,
    input  logic [31:0] id_rs1_data,
    input  logic [31:0] id_rs2_data,
    input  logic [31:0] id_imm,
    input  logic [4:0]  id_rs1_addr,
    input  logic [4:0]  id_rs2_addr,
    input  logic [4:0]  id_rd_addr,
    input  logic [5:0]  id_select,
    input  logic [1:0]  id_op_sel,
    input  logic        flush,
    input  logic [4:0]  exmem_rd_addr,
    input  logic [31:0] exmem_result,
    input  logic [4:0]  memwb_rd_addr,
    input  logic [31:0] memwb_result,
    input  logic        ex_ready,
    output logic [31:0] alu_data1,
    output logic [31:0] alu_data2,
    output logic [5:0]  alu_select,
    output logic        ex_valid,
    output logic [4:0]  ex_rd_addr,
    output logic [31:0] ex_rs2_data
);

    localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    issue_state_e  state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] lat_cycles;
    id_ex_t        id_q;
    id_ex_t        id_in;
    logic [31:0]   d1_h;
    logic [31:0]   d2_h;
    logic [31:0]   rs2_h;
    logic [31:0]   fwd1;
    logic [31:0]   fwd2;
    logic [31:0]   live_d1;
    logic [31:0]   live_d2;
    logic          in_first;
    logic          last_cyc;
    logic          capture;

    operand_forward u_fwd_rs1 (
        .rs_addr       (id_q.rs1_addr),
        .rf_data       (id_q.rs1_data),
        .exmem_rd_addr (exmem_rd_addr),
        .exmem_result  (exmem_result),
        .memwb_rd_addr (memwb_rd_addr),
        .memwb_result  (memwb_result),
        .fwd_data      (fwd1)
    );

    operand_forward u_fwd_rs2 (
        .rs_addr       (id_q.rs2_addr),
        .rf_data       (id_q.rs2_data),
        .exmem_rd_addr (exmem_rd_addr),
        .exmem_result  (exmem_result),
        .memwb_rd_addr (memwb_rd_addr),
        .memwb_result  (memwb_result),
        .fwd_data      (fwd2)
    );

    always_comb begin
        id_in.pc       = id_pc;
        id_in.rs1_data = id_rs1_data;
        id_in.rs2_data = id_rs2_data;
        id_in.imm      = id_imm;
        id_in.rs1_addr = id_rs1_addr;
        id_in.rs2_addr = id_rs2_addr;
        id_in.rd_addr  = id_rd_addr;
        id_in.select   = id_select;
        id_in.op_sel   = id_op_sel;
    end

    always_comb begin
        lat_cycles = CW'(1);
        unique case (lat_class(id_select))
            LAT_MUL: lat_cycles = CW'(MUL_CYCLES);
            LAT_DIV: lat_cycles = CW'(DIV_CYCLES);
            default: lat_cycles = CW'(1);
        endcase
    end

    assign in_first = (state == ST_FIRST);
    assign last_cyc = (in_first || state == ST_WAIT) && (cnt == CW'(1));

    assign live_d1 = id_q.op_sel[OPSEL_PC_BIT]  ? id_q.pc  : fwd1;
    assign live_d2 = id_q.op_sel[OPSEL_IMM_BIT] ? id_q.imm : fwd2;

    // Bypass is only live in FIRST; afterwards the ALU sees frozen copies.
    assign alu_data1   = in_first ? live_d1 : d1_h;
    assign alu_data2   = in_first ? live_d2 : d2_h;
    assign ex_rs2_data = in_first ? fwd2    : rs2_h;
    assign alu_select  = id_q.select;
    assign ex_rd_addr  = id_q.rd_addr;

    assign ex_valid = !flush && (last_cyc || state == ST_DONE);
    assign id_ready = !flush && (state == ST_EMPTY || (ex_valid && ex_ready));
    assign capture  = id_valid && id_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_EMPTY;
            cnt   <= '0;
            id_q  <= '0;
            d1_h  <= '0;
            d2_h  <= '0;
            rs2_h <= '0;
        end else begin
            if (in_first) begin
                d1_h  <= live_d1;
                d2_h  <= live_d2;
                rs2_h <= fwd2;
            end
            if (flush) begin
                state <= ST_EMPTY;
            end else if (capture) begin
                state <= ST_FIRST;
                cnt   <= lat_cycles;
                id_q  <= id_in;
            end else begin
                unique case (state)
                    ST_EMPTY: state <= ST_EMPTY;
                    ST_FIRST,
                    ST_WAIT: begin
                        if (cnt == CW'(1)) begin
                            state <= ex_ready ? ST_EMPTY : ST_DONE;
                        end else begin
                            state <= ST_WAIT;
                            cnt   <= cnt - CW'(1);
                        end
                    end
                    ST_DONE: begin
                        if (ex_ready) state <= ST_EMPTY;
                    end
                    default: state <= ST_EMPTY;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ex_operand_issue.sv
// Directed bench for ex_operand_issue: issue rate, bypass priority,
// multi-cycle hold, backpressure, flush and async reset.
module tb_ex_operand_issue;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_rs1_data;
    logic [31:0] id_rs2_data;
    logic [31:0] id_imm;
    logic [4:0]  id_rs1_addr;
    logic [4:0]  id_rs2_addr;
    logic [4:0]  id_rd_addr;
    logic [5:0]  id_select;
    logic [1:0]  id_op_sel;
    logic        flush;
    logic [4:0]  exmem_rd_addr;
    logic [31:0] exmem_result;
    logic [4:0]  memwb_rd_addr;
    logic [31:0] memwb_result;
    logic        ex_ready;
    logic [31:0] alu_data1;
    logic [31:0] alu_data2;
    logic [5:0]  alu_select;
    logic        ex_valid;
    logic [4:0]  ex_rd_addr;
    logic [31:0] ex_rs2_data;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ex_operand_issue #(.MUL_CYCLES(2), .DIV_CYCLES(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .id_valid      (id_valid),
        .id_ready      (id_ready),
        .id_pc         (id_pc),
        .id_rs1_data   (id_rs1_data),
        .id_rs2_data   (id_rs2_data),
        .id_imm        (id_imm),
        .id_rs1_addr   (id_rs1_addr),
        .id_rs2_addr   (id_rs2_addr),
        .id_rd_addr    (id_rd_addr),
        .id_select     (id_select),
        .id_op_sel     (id_op_sel),
        .flush         (flush),
        .exmem_rd_addr (exmem_rd_addr),
        .exmem_result  (exmem_result),
        .memwb_rd_addr (memwb_rd_addr),
        .memwb_result  (memwb_result),
        .ex_ready      (ex_ready),
        .alu_data1     (alu_data1),
        .alu_data2     (alu_data2),
        .alu_select    (alu_select),
        .ex_valid      (ex_valid),
        .ex_rd_addr    (ex_rd_addr),
        .ex_rs2_data   (ex_rs2_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] a1,
                          input logic [31:0] d1, input logic [4:0] a2,
                          input logic [31:0] d2, input logic [4:0] rd,
                          input logic [5:0] sel, input logic [1:0] os);
        id_valid    = v;
        id_rs1_addr = a1;
        id_rs1_data = d1;
        id_rs2_addr = a2;
        id_rs2_data = d2;
        id_rd_addr  = rd;
        id_select   = sel;
        id_op_sel   = os;
    endtask

    initial begin
        reset         = 1'b1;
        flush         = 1'b0;
        ex_ready      = 1'b1;
        id_pc         = 32'h0000_1000;
        id_imm        = 32'h0000_1234;
        exmem_rd_addr = 5'd0;
        exmem_result  = 32'h0;
        memwb_rd_addr = 5'd0;
        memwb_result  = 32'h0;
        set_id(1'b0, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 6'd0, 2'b00);

        // reset state
        #3;
        chk("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_id_ready", {31'd0, id_ready}, 32'd1);
        chk("rst_data1", alu_data1, 32'd0);
        chk("rst_data2", alu_data2, 32'd0);
        chk("rst_select", {26'd0, alu_select}, 32'd0);
        chk("rst_rd", {27'd0, ex_rd_addr}, 32'd0);
        next_cycle();
        reset = 1'b0;

        // 1: back-to-back ADD
        next_cycle();
        set_id(1'b1, 5'd1, 32'd5, 5'd2, 32'd7, 5'd10, 6'b000000, 2'b00);
        #2;
        chk("t1_a_ready", {31'd0, id_ready}, 32'd1);
        chk("t1_a_valid", {31'd0, ex_valid}, 32'd0);
        next_cycle();
        id_rd_addr = 5'd11;
        #2;
        chk("t1_b_valid", {31'd0, ex_valid}, 32'd1);
        chk("t1_b_d1", alu_data1, 32'd5);
        chk("t1_b_d2", alu_data2, 32'd7);
        chk("t1_b_sel", {26'd0, alu_select}, 32'd0);
        chk("t1_b_rd", {27'd0, ex_rd_addr}, 32'd10);
        chk("t1_b_ready", {31'd0, id_ready}, 32'd1);
        next_cycle();
        id_valid = 1'b0;
        #2;
        chk("t1_c_valid", {31'd0, ex_valid}, 32'd1);
        chk("t1_c_rd", {27'd0, ex_rd_addr}, 32'd11);
        chk("t1_c_d1", alu_data1, 32'd5);
        next_cycle();
        #2;
        chk("t1_d_valid", {31'd0, ex_valid}, 32'd0);

        // 2: bypass priority, IMM bypass, x0, PC operand
        next_cycle();
        set_id(1'b1, 5'd3, 32'h99, 5'd3, 32'h77, 5'd12, 6'b000000, 2'b10);
        next_cycle();
        id_valid      = 1'b0;
        exmem_rd_addr = 5'd3;
        exmem_result  = 32'h11;
        memwb_rd_addr = 5'd3;
        memwb_result  = 32'h22;
        #2;
        chk("t2_exmem_d1", alu_data1, 32'h11);
        chk("t2_imm_d2", alu_data2, 32'h1234);
        chk("t2_rs2_fwd", ex_rs2_data, 32'h11);
        exmem_rd_addr = 5'd0;
        #2;
        chk("t2_memwb_d1", alu_data1, 32'h22);
        chk("t2_memwb_rs2", ex_rs2_data, 32'h22);
        memwb_rd_addr = 5'd0;
        #2;
        chk("t2_rf_d1", alu_data1, 32'h99);
        next_cycle();
        set_id(1'b1, 5'd0, 32'h0, 5'd6, 32'h66, 5'd13, 6'b000000, 2'b00);
        exmem_result = 32'h11;
        memwb_result = 32'h22;
        next_cycle();
        set_id(1'b1, 5'd1, 32'h55, 5'd2, 32'h66, 5'd14, 6'b000000, 2'b01);
        #2;
        chk("t2_x0_d1", alu_data1, 32'h0);
        next_cycle();
        id_valid = 1'b0;
        #2;
        chk("t2_pc_d1", alu_data1, 32'h0000_1000);
        chk("t2_pc_d2", alu_data2, 32'h66);

        // 3: DIV holds first-cycle operands for 4 cycles
        next_cycle();
        set_id(1'b1, 5'd4, 32'h5, 5'd0, 32'h0, 5'd12, 6'b001100, 2'b00);
        exmem_rd_addr = 5'd4;
        exmem_result  = 32'hAAA;
        next_cycle();
        set_id(1'b1, 5'd9, 32'h42, 5'd0, 32'h0, 5'd20, 6'b000000, 2'b00);
        #2;
        chk("t3_c1_d1", alu_data1, 32'hAAA);
        chk("t3_c1_valid", {31'd0, ex_valid}, 32'd0);
        chk("t3_c1_ready", {31'd0, id_ready}, 32'd0);
        chk("t3_c1_sel", {26'd0, alu_select}, 32'h0C);
        next_cycle();
        exmem_result = 32'hBBB;
        #2;
        chk("t3_c2_d1", alu_data1, 32'hAAA);
        chk("t3_c2_valid", {31'd0, ex_valid}, 32'd0);
        chk("t3_c2_ready", {31'd0, id_ready}, 32'd0);
        next_cycle();
        exmem_result = 32'hCCC;
        #2;
        chk("t3_c3_d1", alu_data1, 32'hAAA);
        chk("t3_c3_valid", {31'd0, ex_valid}, 32'd0);
        chk("t3_c3_ready", {31'd0, id_ready}, 32'd0);
        next_cycle();
        exmem_result = 32'hDDD;
        #2;
        chk("t3_c4_valid", {31'd0, ex_valid}, 32'd1);
        chk("t3_c4_d1", alu_data1, 32'hAAA);
        chk("t3_c4_rd", {27'd0, ex_rd_addr}, 32'd12);
        chk("t3_c4_ready", {31'd0, id_ready}, 32'd1);
        next_cycle();
        id_valid = 1'b0;
        #2;
        chk("t3_next_valid", {31'd0, ex_valid}, 32'd1);
        chk("t3_next_rd", {27'd0, ex_rd_addr}, 32'd20);
        chk("t3_next_d1", alu_data1, 32'h42);
        exmem_rd_addr = 5'd0;

        // 4: backpressure on a 1-cycle op
        next_cycle();
        set_id(1'b1, 5'd1, 32'h10, 5'd2, 32'h20, 5'd7, 6'b000001, 2'b00);
        ex_ready = 1'b0;
        next_cycle();
        set_id(1'b1, 5'd1, 32'h99, 5'd2, 32'h88, 5'd8, 6'b000010, 2'b00);
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin
                memwb_rd_addr = 5'd1;
                memwb_result  = 32'hEE;
            end
            #2;
            chk("t4_valid", {31'd0, ex_valid}, 32'd1);
            chk("t4_d1", alu_data1, 32'h10);
            chk("t4_d2", alu_data2, 32'h20);
            chk("t4_sel", {26'd0, alu_select}, 32'h01);
            chk("t4_ready", {31'd0, id_ready}, 32'd0);
            next_cycle();
        end
        id_valid = 1'b0;
        ex_ready = 1'b1;
        memwb_rd_addr = 5'd0;
        #2;
        chk("t4_rel_valid", {31'd0, ex_valid}, 32'd1);
        chk("t4_rel_rd", {27'd0, ex_rd_addr}, 32'd7);
        chk("t4_rel_ready", {31'd0, id_ready}, 32'd1);
        next_cycle();
        #2;
        chk("t4_empty_valid", {31'd0, ex_valid}, 32'd0);

        // 5: flush during cycle 2 of MUL
        next_cycle();
        set_id(1'b1, 5'd1, 32'h3, 5'd2, 32'h4, 5'd21, 6'b001000, 2'b00);
        next_cycle();
        set_id(1'b0, 5'd1, 32'h3, 5'd2, 32'h4, 5'd21, 6'b001000, 2'b00);
        #2;
        chk("t5_c1_valid", {31'd0, ex_valid}, 32'd0);
        chk("t5_c1_ready", {31'd0, id_ready}, 32'd0);
        next_cycle();
        set_id(1'b1, 5'd1, 32'h9, 5'd2, 32'h9, 5'd25, 6'b000000, 2'b00);
        flush = 1'b1;
        #2;
        chk("t5_fl_valid", {31'd0, ex_valid}, 32'd0);
        chk("t5_fl_ready", {31'd0, id_ready}, 32'd0);
        next_cycle();
        flush    = 1'b0;
        id_valid = 1'b0;
        #2;
        chk("t5_after_valid", {31'd0, ex_valid}, 32'd0);
        chk("t5_after_ready", {31'd0, id_ready}, 32'd1);

        // 6: async reset in the middle of a DIV
        next_cycle();
        set_id(1'b1, 5'd1, 32'h31, 5'd2, 32'h32, 5'd26, 6'b001100, 2'b00);
        next_cycle();
        id_valid = 1'b0;
        next_cycle();
        #1;
        chk("t6_wait_ready", {31'd0, id_ready}, 32'd0);
        chk("t6_wait_sel", {26'd0, alu_select}, 32'h0C);
        reset = 1'b1;
        #1;
        chk("t6_rst_valid", {31'd0, ex_valid}, 32'd0);
        chk("t6_rst_ready", {31'd0, id_ready}, 32'd1);
        chk("t6_rst_d1", alu_data1, 32'd0);
        chk("t6_rst_sel", {26'd0, alu_select}, 32'd0);
        next_cycle();
        reset = 1'b0;
        next_cycle();
        next_cycle();
        #2;
        chk("t6_post_valid", {31'd0, ex_valid}, 32'd0);
        chk("t6_post_ready", {31'd0, id_ready}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
